// File: rtl/vga_pkg.sv
// Shared screen geometry, framebuffer entry layout and pixel address helper
// for the VGA plot path.
package vga_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int FB_AW    = 15;

    typedef struct packed {
        logic [FB_AW-1:0] addr;
        logic [2:0]       colour;
    } fb_entry_t;

    // y*160 + x as y*128 + y*32 + x; worst case 19199 fits in FB_AW bits.
    function automatic logic [FB_AW-1:0] pixel_addr(input logic [7:0] x, input logic [6:0] y);
        logic [FB_AW-1:0] yw;
        logic [FB_AW-1:0] xw;
        yw = {8'b0, y};
        xw = {7'b0, x};
        return (yw << 7) + (yw << 5) + xw;
    endfunction

endpackage

// File: rtl/plot_fifo.sv
// Circular FIFO holding pending framebuffer writes; the space flag is
// registered so the upstream ready never depends on this cycle's pop.
module plot_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             not_full
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW:0]      count_q, count_d;
    logic             not_full_q, not_full_d;
    logic             do_push, do_pop;

    assign do_push = push && not_full_q;
    assign do_pop  = pop && (count_q != '0);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (do_pop) begin
            rptr_d = rptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
        not_full_d = (count_d < FULL_CNT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            not_full_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            not_full_q <= not_full_d;
        end
    end

    // Storage needs no reset: contents are only visible through a nonzero count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata;
        end
    end

    assign rdata    = mem_q[rptr_q];
    assign empty    = (count_q == '0);
    assign not_full = not_full_q;

endmodule

// File: rtl/vga_plot_buffer.sv
// Decouples the drawing engine from the framebuffer: clips off-screen pixels,
// converts (x, y) to a linear address and queues writes in order.
module vga_plot_buffer
    import vga_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_x,
    input  logic [6:0]  in_y,
    input  logic [2:0]  in_colour,
    input  logic        in_plot,
    output logic        in_ready,
    output logic [14:0] fb_addr,
    output logic [2:0]  fb_data,
    output logic        fb_we,
    input  logic        fb_ready,
    output logic        empty,
    output logic [15:0] clip_count
);

    localparam int unsigned ENTRY_W = $bits(fb_entry_t);
    localparam logic [7:0] X_LIM = 8'(SCREEN_W);
    localparam logic [6:0] Y_LIM = 7'(SCREEN_H);

    logic               accept;
    logic               on_screen;
    logic               store;
    logic               clip_hit;
    logic               fifo_empty;
    logic               fifo_not_full;
    logic               pop;
    fb_entry_t          wr_entry;
    fb_entry_t          rd_entry;
    logic [ENTRY_W-1:0] rd_bits;
    logic [15:0]        clip_count_q, clip_count_d;

    assign accept    = in_plot && fifo_not_full;
    assign on_screen = (in_x < X_LIM) && (in_y < Y_LIM);
    assign store     = accept && on_screen;
    assign clip_hit  = accept && !on_screen;

    assign wr_entry.addr   = pixel_addr(in_x, in_y);
    assign wr_entry.colour = in_colour;

    assign fb_we = !fifo_empty;
    assign pop   = fb_we && fb_ready;

    plot_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (store),
        .wdata    (wr_entry),
        .pop      (pop),
        .rdata    (rd_bits),
        .empty    (fifo_empty),
        .not_full (fifo_not_full)
    );

    assign rd_entry = fb_entry_t'(rd_bits);
    assign fb_addr  = rd_entry.addr;
    assign fb_data  = rd_entry.colour;
    assign empty    = fifo_empty;
    assign in_ready = fifo_not_full;

    always_comb begin
        clip_count_d = clip_count_q;
        if (clip_hit && (clip_count_q != 16'hFFFF)) begin
            clip_count_d = clip_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clip_count_q <= '0;
        end else begin
            clip_count_q <= clip_count_d;
        end
    end

    assign clip_count = clip_count_q;

endmodule

// File: tb/tb_vga_plot_buffer.sv
// Self-checking bench for vga_plot_buffer: directed vectors, backpressure,
// full-screen random-ready stream and mid-burst reset against a queue model.
module tb_vga_plot_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_x = '0;
    logic [6:0]  in_y = '0;
    logic [2:0]  in_colour = '0;
    logic        in_plot = 1'b0;
    logic        in_ready;
    logic [14:0] fb_addr;
    logic [2:0]  fb_data;
    logic        fb_we;
    logic        fb_ready = 1'b0;
    logic        empty;
    logic [15:0] clip_count;

    always #5 clk = ~clk;

    vga_plot_buffer #(.DEPTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_x       (in_x),
        .in_y       (in_y),
        .in_colour  (in_colour),
        .in_plot    (in_plot),
        .in_ready   (in_ready),
        .fb_addr    (fb_addr),
        .fb_data    (fb_data),
        .fb_we      (fb_we),
        .fb_ready   (fb_ready),
        .empty      (empty),
        .clip_count (clip_count)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of pending (addr, colour) writes and a clip tally.
    typedef struct {
        int addr;
        int colour;
    } exp_t;

    exp_t q[$];
    int   clip_m = 0;
    bit   fill_mode = 1'b0;
    int   wr_cnt [19200];
    int   wr_col [19200];
    int   fill_writes = 0;

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_fb_we", fb_we, 0);
            chk("rst_empty", empty, 1);
            chk("rst_in_ready", in_ready, 0);
            chk("rst_clip_count", clip_count, 0);
            q.delete();
            clip_m = 0;
        end else begin
            bit ready_m;
            ready_m = (q.size() < 8);
            chk("in_ready", in_ready, ready_m);
            chk("fb_we", fb_we, q.size() != 0);
            chk("empty", empty, q.size() == 0);
            chk("clip_count", clip_count, clip_m);
            if (q.size() != 0) begin
                chk("fb_addr", fb_addr, q[0].addr);
                chk("fb_data", fb_data, q[0].colour);
                if (fb_ready) begin
                    if (fill_mode) begin
                        wr_cnt[q[0].addr]++;
                        wr_col[q[0].addr] = fb_data;
                        fill_writes++;
                    end
                    void'(q.pop_front());
                end
            end
            if (in_plot && ready_m) begin
                if (in_x >= 160 || in_y >= 120) begin
                    if (clip_m != 65535) clip_m++;
                end else begin
                    q.push_back('{int'(in_y) * 160 + int'(in_x), int'(in_colour)});
                end
            end
        end
    end

    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
        bit         clipped;
        int         addr;
    } vec_t;

    vec_t vt [7];

    task automatic release_reset();
        @(negedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic wait_empty(input string name);
        int cyc;
        cyc = 0;
        while (!empty && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk(name, empty, 1);
    endtask

    initial begin
        int n_clip;
        int accepted;
        int cyc;
        int idx;
        bit acc;
        int missing;
        int bad_col;

        vt[0] = '{8'd5,   7'd3,   3'b010, 1'b0, 485};
        vt[1] = '{8'd159, 7'd119, 3'b111, 1'b0, 19199};
        vt[2] = '{8'd160, 7'd0,   3'b001, 1'b1, 0};
        vt[3] = '{8'd0,   7'd120, 3'b101, 1'b1, 0};
        vt[4] = '{8'd0,   7'd0,   3'b100, 1'b0, 0};
        vt[5] = '{8'd100, 7'd50,  3'b011, 1'b0, 8100};
        vt[6] = '{8'd255, 7'd127, 3'b110, 1'b1, 0};

        rst = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        release_reset();
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_fb_we", fb_we, 0);
        chk("post_rst_empty", empty, 1);
        chk("post_rst_clip", clip_count, 0);

        // Directed single pixels with the framebuffer always ready.
        fb_ready = 1'b1;
        n_clip = 0;
        for (int i = 0; i < 7; i++) begin
            in_x = vt[i].x;
            in_y = vt[i].y;
            in_colour = vt[i].c;
            in_plot = 1'b1;
            @(posedge clk);
            #1 in_plot = 1'b0;
            if (vt[i].clipped) begin
                n_clip++;
                chk("vec_clip_no_we", fb_we, 0);
                chk("vec_clip_count", clip_count, n_clip);
            end else begin
                chk("vec_we", fb_we, 1);
                chk("vec_addr", fb_addr, vt[i].addr);
                chk("vec_data", fb_data, vt[i].c);
            end
            @(posedge clk);
            #1;
            chk("vec_empty_after", empty, 1);
        end

        // Backpressure: eight accepted, ninth held until a pop frees space.
        fb_ready = 1'b0;
        accepted = 0;
        cyc = 0;
        in_x = 8'd0; in_y = 7'd0; in_colour = 3'd0;
        in_plot = 1'b1;
        while (accepted < 8 && cyc < 20) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                accepted++;
                in_x = 8'(accepted * 17);
                in_y = 7'((accepted * 13) % 120);
                in_colour = 3'(accepted);
            end
            cyc++;
        end
        chk("bp_accepted", accepted, 8);
        repeat (3) begin
            @(negedge clk);
            chk("bp_full_ready", in_ready, 0);
        end
        @(posedge clk);
        #1 fb_ready = 1'b1;
        @(negedge clk);
        chk("bp_pop_same_cycle_ready", in_ready, 0);
        @(negedge clk);
        chk("bp_pop_next_ready", in_ready, 1);
        @(posedge clk);
        #1 in_plot = 1'b0;
        wait_empty("bp_drain_empty");

        // Full-screen stream in fillscreen order with random framebuffer stalls.
        for (int a = 0; a < 19200; a++) begin
            wr_cnt[a] = 0;
            wr_col[a] = 0;
        end
        fill_mode = 1'b1;
        idx = 0;
        cyc = 0;
        in_plot = 1'b1;
        while (idx < 19200 && cyc < 60000) begin
            in_x = 8'(idx / 120);
            in_y = 7'(idx % 120);
            in_colour = 3'((idx / 120) % 8);
            fb_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) idx++;
            cyc++;
        end
        in_plot = 1'b0;
        fb_ready = 1'b1;
        chk("fill_all_accepted", idx, 19200);
        wait_empty("fill_drain_empty");
        @(negedge clk);
        fill_mode = 1'b0;
        missing = 0;
        bad_col = 0;
        for (int a = 0; a < 19200; a++) begin
            if (wr_cnt[a] != 1) missing++;
            if (wr_col[a] != (a % 160) % 8) bad_col++;
        end
        chk("fill_writes", fill_writes, 19200);
        chk("fill_addr_once", missing, 0);
        chk("fill_colour", bad_col, 0);

        // Mid-burst reset: four writes pending, reset must drop fb_we at once.
        @(posedge clk);
        #1 fb_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_x = 8'(10 + i);
            in_y = 7'(20 + i);
            in_colour = 3'(i);
            in_plot = 1'b1;
            @(posedge clk);
            #1;
        end
        in_plot = 1'b0;
        chk("burst_pending_we", fb_we, 1);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("async_rst_fb_we", fb_we, 0);
        chk("async_rst_empty", empty, 1);
        release_reset();
        fb_ready = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("no_stale_we", fb_we, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
